// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-side bundle of the multiply/divide unit: issue, operands, hazard
// and HI/LO read-back.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_in_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, md_in_d,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, md_in_d,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit multiply and 32-bit divide/remainder for the MDU.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0]        prod;

    assign sa       = a;
    assign sb       = b;
    assign div_zero = (b == 32'd0);

    always_comb begin
        prod   = 64'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            // Sign-extending to 64 bits makes the low 64 bits of the product
            // the correct two's-complement result.
            OP_MULT: begin
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV: begin
                if (!div_zero) begin
                    res_lo = sa / sb;
                    res_hi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: issue FSM, latency counter, operand latches
// and the architectural HI/LO registers.
module mdu_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic     clk,
    input  logic     reset,
    mdu_ctrl_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic               busy_q;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_zero;

    md_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.md_op)
                            OP_MULT, OP_MULTU: begin
                                op_q   <= bus.md_op;
                                a_q    <= bus.src_a;
                                b_q    <= bus.src_b;
                                cnt    <= CNT_W'(MULT_CYCLES);
                                state  <= ST_MUL;
                                busy_q <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q   <= bus.md_op;
                                a_q    <= bus.src_a;
                                b_q    <= bus.src_b;
                                cnt    <= CNT_W'(DIV_CYCLES);
                                state  <= ST_DIV;
                                busy_q <= 1'b1;
                            end
                            OP_MTHI: hi_q <= bus.src_a;
                            OP_MTLO: lo_q <= bus.src_a;
                            default: ;
                        endcase
                    end
                end
                // New starts are ignored here; the latched operands drive md_arith.
                ST_MUL, ST_DIV: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        if (!(state == ST_DIV && div_zero)) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.stall_md = bus.md_in_d & (busy_q | (bus.start & is_long_op(bus.md_op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for each op plus hand-written
// stall, back-to-back MTHI/MTLO and mid-operation reset sequences.
module tb_mdu_ctrl;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mdu_ctrl_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, scramble operands during busy, count busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int ncyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        ncyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            ncyc++;
            bus.src_a = $urandom;
            bus.src_b = $urandom;
        end
    endtask

    initial begin
        int ncyc;
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[5] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[6] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
        vecs[7] = '{OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'd0,        0};
        vecs[8] = '{OP_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[9] = '{3'd6,     32'd5,        32'd5,        32'h12345678, 32'h9ABCDEF0, 0};

        bus.start   = 1'b0;
        bus.md_op   = 3'd0;
        bus.src_a   = 32'd0;
        bus.src_b   = 32'd0;
        bus.md_in_d = 1'b0;
        reset       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  {31'd0, bus.busy},     32'd0);
        check("reset_stall", {31'd0, bus.stall_md}, 32'd0);
        check("reset_hi",    bus.hi,                32'd0);
        check("reset_lo",    bus.lo,                32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, ncyc);
            check($sformatf("vec%0d_cycles", i), 32'(ncyc), 32'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
        end

        // DIV with a D-stage HI/LO user waiting; a second start mid-busy is ignored.
        @(negedge clk);
        bus.md_in_d = 1'b1;
        bus.start   = 1'b1;
        bus.md_op   = OP_DIV;
        bus.src_a   = 32'd20;
        bus.src_b   = 32'd3;
        #1;
        check("stall_start_cycle", {31'd0, bus.stall_md}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                bus.start = 1'b1;
                bus.md_op = OP_MTHI;
                bus.src_a = 32'hDEADBEEF;
            end
            if (c == 6) begin
                bus.start = 1'b1;
                bus.md_op = OP_MULT;
                bus.src_a = 32'd9;
                bus.src_b = 32'd9;
            end
            check($sformatf("stall_busy_c%0d", c), {30'd0, bus.busy, bus.stall_md}, 32'd3);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        check("stall_after",    {30'd0, bus.busy, bus.stall_md}, 32'd0);
        check("stall_div_hi",   bus.hi, 32'd2);
        check("stall_div_lo",   bus.lo, 32'd6);
        bus.md_in_d = 1'b0;

        // Back-to-back MTHI then MTLO.
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = OP_MTHI;
        bus.src_a = 32'hAAAA0001;
        @(posedge clk);
        #1;
        bus.md_op = OP_MTLO;
        bus.src_a = 32'hBBBB0002;
        check("mt_hi",   bus.hi, 32'hAAAA0001);
        check("mt_lo0",  bus.lo, 32'd6);
        check("mt_busy0", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mt_lo",    bus.lo, 32'hBBBB0002);
        check("mt_hi1",   bus.hi, 32'hAAAA0001);
        check("mt_busy1", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset during busy cycle 3 of a MULT.
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = OP_MULT;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_async_hi",   bus.hi, 32'd0);
        check("rst_async_lo",   bus.lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_no_commit_hi", bus.hi, 32'd0);
        check("rst_no_commit_lo", bus.lo, 32'd0);
        check("rst_idle_busy",    {31'd0, bus.busy}, 32'd0);

        // First start after reset release is honoured.
        run_op(OP_MULTU, 32'd2, 32'd3, ncyc);
        check("post_rst_cycles", 32'(ncyc), 32'd5);
        check("post_rst_hi",     bus.hi, 32'd0);
        check("post_rst_lo",     bus.lo, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
